// File: rtl/high_bit_grant_scheduler_if.sv
// Request/grant bundle between a requester-side agent and the high-bit grant scheduler.
// The master drives requests and grant handshakes; the slave (scheduler) reports grant state.
interface high_bit_grant_scheduler_if #(
   parameter int unsigned REQ_WIDTH = 8
);
   localparam int unsigned ID_WIDTH = $clog2(REQ_WIDTH);

   logic [REQ_WIDTH-1:0] req_in;
   logic                 grant_ready;
   logic                 done;
   logic                 grant_valid;
   logic [ID_WIDTH-1:0]  grant_id;
   logic                 busy;
   logic [REQ_WIDTH-1:0] pending;

   modport master (
      output req_in,
      output grant_ready,
      output done,
      input  grant_valid,
      input  grant_id,
      input  busy,
      input  pending
   );

   modport slave (
      input  req_in,
      input  grant_ready,
      input  done,
      output grant_valid,
      output grant_id,
      output busy,
      output pending
   );
endinterface

// File: rtl/high_bit_grant_scheduler.sv
// Fixed-priority (highest index wins) grant scheduler with sticky pending requests.
// The winning index is resolved one bit per cycle, MSB first, over a frozen snapshot.
module high_bit_grant_scheduler #(
   parameter int unsigned REQ_WIDTH = 8
) (
   input logic                       clk,
   input logic                       rst,
   high_bit_grant_scheduler_if.slave bus
);

   localparam int unsigned ID_WIDTH   = $clog2(REQ_WIDTH);
   localparam int unsigned SEARCH_LAT = (ID_WIDTH > 1) ? ID_WIDTH : 1;
   localparam int unsigned CNT_WIDTH  = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSearch = 2'd1;
   localparam logic [1:0] StOffer  = 2'd2;
   localparam logic [1:0] StActive = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [REQ_WIDTH-1:0] pending_q, pending_d;
   logic [REQ_WIDTH-1:0] snap_q, snap_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [ID_WIDTH-1:0]  idx_q, idx_d;
   logic [ID_WIDTH-1:0]  gid_q, gid_d;

   logic [REQ_WIDTH-1:0] clear_mask;
   logic [ID_WIDTH-1:0]  idx_step;
   logic                 upper_hit;
   int unsigned          bit_sel;
   logic [31:0]          idx_ext;

   // Search step: index bit cnt_q is set when some snapshot bit shares the already-resolved
   // higher index bits and has bit cnt_q set.
   always_comb begin
      bit_sel   = 32'(cnt_q);
      idx_ext   = 32'(idx_q);
      upper_hit = 1'b0;
      for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
         if (snap_q[i] && i[bit_sel] &&
             ((i >> (bit_sel + 1)) == (idx_ext >> (bit_sel + 1)))) begin
            upper_hit = 1'b1;
         end
      end
      idx_step          = idx_q;
      idx_step[cnt_q]   = upper_hit;
   end

   // A request arriving on the bit being cleared wins, so it is never lost.
   always_comb begin
      clear_mask = '0;
      if (state_q == StOffer && bus.grant_ready) begin
         clear_mask = REQ_WIDTH'(1) << gid_q;
      end
      pending_d = (pending_q & ~clear_mask) | bus.req_in;
   end

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      gid_d   = gid_q;
      case (state_q)
         StIdle: begin
            if (|pending_q) begin
               snap_d  = pending_q;
               cnt_d   = CNT_WIDTH'(SEARCH_LAT - 1);
               idx_d   = '0;
               state_d = StSearch;
            end
         end
         StSearch: begin
            idx_d = idx_step;
            if (cnt_q == '0) begin
               gid_d   = idx_step;
               state_d = StOffer;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         StOffer: begin
            if (bus.grant_ready) begin
               state_d = StActive;
            end
         end
         StActive: begin
            if (bus.done) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         pending_q <= '0;
         snap_q    <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         gid_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         snap_q    <= snap_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         gid_q     <= gid_d;
      end
   end

   assign bus.grant_valid = (state_q == StOffer);
   assign bus.busy        = (state_q == StActive);
   assign bus.grant_id    = gid_q;
   assign bus.pending     = pending_q;

endmodule

// File: tb/tb_high_bit_grant_scheduler.sv
// Directed bench for high_bit_grant_scheduler at REQ_WIDTH = 8 (SEARCH_LAT = 3).
// Inputs change 1 time unit after each rising edge; outputs are read at that same point.
module tb_high_bit_grant_scheduler;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   high_bit_grant_scheduler_if #(.REQ_WIDTH(8)) hb ();

   high_bit_grant_scheduler #(.REQ_WIDTH(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(hb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && hb.grant_valid && hb.busy) begin
         $display("FAIL exclusive: grant_valid=%b busy=%b, required not both high",
                  hb.grant_valid, hb.busy);
         miscompares++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_req(input logic [7:0] r);
      hb.req_in = r;
      tick();
      hb.req_in = 8'h00;
   endtask

   task automatic wait_offer(output int n);
      n = 0;
      while (!hb.grant_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic accept();
      hb.grant_ready = 1'b1;
      tick();
      hb.grant_ready = 1'b0;
   endtask

   task automatic finish_grant();
      hb.done = 1'b1;
      tick();
      hb.done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      vectors++;
      if (hb.grant_valid !== 1'b0 || hb.busy !== 1'b0 || hb.grant_id !== 3'd0 ||
          hb.pending !== 8'h00) begin
         $display("FAIL reset: valid=%b busy=%b id=%0d pending=%h, required 0 0 0 00",
                  hb.grant_valid, hb.busy, hb.grant_id, hb.pending);
         miscompares++;
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_latency();
      pulse_req(8'h01);
      tick();
      tick();
      tick();
      vectors++;
      if (hb.grant_valid !== 1'b0) begin
         $display("FAIL latency_c4: grant_valid=%b, required 0", hb.grant_valid);
         miscompares++;
      end
      tick();
      vectors++;
      if (hb.grant_valid !== 1'b1 || hb.grant_id !== 3'd0) begin
         $display("FAIL latency_c5: valid=%b id=%0d, required 1 0", hb.grant_valid, hb.grant_id);
         miscompares++;
      end
      accept();
      vectors++;
      if (hb.busy !== 1'b1 || hb.grant_valid !== 1'b0 || hb.pending !== 8'h00) begin
         $display("FAIL latency_c6: busy=%b valid=%b pending=%h, required 1 0 00",
                  hb.busy, hb.grant_valid, hb.pending);
         miscompares++;
      end
      finish_grant();
      vectors++;
      if (hb.busy !== 1'b0 || hb.grant_valid !== 1'b0) begin
         $display("FAIL latency_done: busy=%b valid=%b, required 0 0", hb.busy, hb.grant_valid);
         miscompares++;
      end
   endtask

   task automatic test_priority();
      logic [2:0] exp_id[3];
      logic [7:0] exp_pend[3];
      int n;
      exp_id[0] = 3'd5; exp_id[1] = 3'd3; exp_id[2] = 3'd0;
      exp_pend[0] = 8'h09; exp_pend[1] = 8'h01; exp_pend[2] = 8'h00;
      pulse_req(8'h29);
      for (int k = 0; k < 3; k++) begin
         wait_offer(n);
         vectors++;
         if (hb.grant_valid !== 1'b1 || hb.grant_id !== exp_id[k] || n != 4) begin
            $display("FAIL priority_grant%0d: valid=%b id=%0d wait=%0d, required 1 %0d 4",
                     k, hb.grant_valid, hb.grant_id, n, exp_id[k]);
            miscompares++;
         end
         accept();
         vectors++;
         if (hb.pending !== exp_pend[k] || hb.busy !== 1'b1) begin
            $display("FAIL priority_pend%0d: pending=%h busy=%b, required %h 1",
                     k, hb.pending, hb.busy, exp_pend[k]);
            miscompares++;
         end
         finish_grant();
      end
   endtask

   task automatic test_no_preempt();
      int n;
      pulse_req(8'h02);
      wait_offer(n);
      accept();
      pulse_req(8'h80);
      tick();
      tick();
      vectors++;
      if (hb.grant_id !== 3'd1 || hb.busy !== 1'b1 || hb.pending !== 8'h80) begin
         $display("FAIL no_preempt: id=%0d busy=%b pending=%h, required 1 1 80",
                  hb.grant_id, hb.busy, hb.pending);
         miscompares++;
      end
      finish_grant();
      wait_offer(n);
      vectors++;
      if (hb.grant_valid !== 1'b1 || hb.grant_id !== 3'd7) begin
         $display("FAIL no_preempt_next: valid=%b id=%0d, required 1 7",
                  hb.grant_valid, hb.grant_id);
         miscompares++;
      end
      accept();
      finish_grant();
   endtask

   task automatic test_same_cycle();
      int n;
      pulse_req(8'h10);
      wait_offer(n);
      hb.req_in = 8'h10;
      accept();
      hb.req_in = 8'h00;
      vectors++;
      if (hb.pending !== 8'h10 || hb.busy !== 1'b1) begin
         $display("FAIL same_cycle_pend: pending=%h busy=%b, required 10 1", hb.pending, hb.busy);
         miscompares++;
      end
      finish_grant();
      wait_offer(n);
      vectors++;
      if (hb.grant_valid !== 1'b1 || hb.grant_id !== 3'd4) begin
         $display("FAIL same_cycle_regrant: valid=%b id=%0d, required 1 4",
                  hb.grant_valid, hb.grant_id);
         miscompares++;
      end
      accept();
      finish_grant();
      vectors++;
      if (hb.pending !== 8'h00) begin
         $display("FAIL same_cycle_drain: pending=%h, required 00", hb.pending);
         miscompares++;
      end
   endtask

   task automatic test_hold();
      int n;
      pulse_req(8'h40);
      wait_offer(n);
      for (int i = 0; i < 20; i++) begin
         hb.done = (i % 2 == 0);
         tick();
         vectors++;
         if (hb.grant_valid !== 1'b1 || hb.grant_id !== 3'd6 || hb.busy !== 1'b0) begin
            $display("FAIL hold_c%0d: valid=%b id=%0d busy=%b, required 1 6 0",
                     i, hb.grant_valid, hb.grant_id, hb.busy);
            miscompares++;
         end
      end
      hb.done = 1'b0;
      accept();
      finish_grant();
   endtask

   task automatic test_reset_midflight();
      int n;
      int seen;
      pulse_req(8'h04);
      wait_offer(n);
      accept();
      pulse_req(8'h44);
      vectors++;
      if (hb.pending !== 8'h44 || hb.busy !== 1'b1 || hb.grant_id !== 3'd2) begin
         $display("FAIL rst_active_pre: pending=%h busy=%b id=%0d, required 44 1 2",
                  hb.pending, hb.busy, hb.grant_id);
         miscompares++;
      end
      rst = 1'b1;
      hb.req_in = 8'h01;
      tick();
      rst = 1'b0;
      hb.req_in = 8'h00;
      vectors++;
      if (hb.grant_valid !== 1'b0 || hb.busy !== 1'b0 || hb.grant_id !== 3'd0 ||
          hb.pending !== 8'h00) begin
         $display("FAIL rst_active: valid=%b busy=%b id=%0d pending=%h, required 0 0 0 00",
                  hb.grant_valid, hb.busy, hb.grant_id, hb.pending);
         miscompares++;
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (hb.grant_valid || hb.busy) seen++;
      end
      vectors++;
      if (seen != 0) begin
         $display("FAIL rst_quiet: %0d cycles with grant activity, required 0", seen);
         miscompares++;
      end
      pulse_req(8'h08);
      wait_offer(n);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (hb.grant_valid !== 1'b0 || hb.pending !== 8'h00 || hb.grant_id !== 3'd0) begin
         $display("FAIL rst_offer: valid=%b pending=%h id=%0d, required 0 00 0",
                  hb.grant_valid, hb.pending, hb.grant_id);
         miscompares++;
      end
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst            = 1'b1;
      hb.req_in      = 8'h00;
      hb.grant_ready = 1'b0;
      hb.done        = 1'b0;
      test_reset();
      test_latency();
      test_priority();
      test_no_preempt();
      test_same_cycle();
      test_hold();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
